alu_exec_unit: RTL and testbench

- Sequential execution unit; the consumer end of the 4-bit ALU control word (ALU_Cnt) produced by the ALU control decoder.
- Latches the operands and the control word on a start strobe.
- Logic, arithmetic and pass operations complete in one cycle. Shifts and rotates take one cycle per bit position.
- Returns a registered result, S/Z/C/V flags and a done pulse to the processor phase controller.

---
 rtl/alu_exec_unit.sv | 205 ++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// -----------------------------------------------------------------------------
// Sequential execution unit that consumes the 4-bit ALU control word.
// Operands, opcode and shift amount are captured on the alu_e strobe.
// Most ops finish in one cycle. A shift or rotate by N > 0 steps its working
// register one bit per clock and finishes N clocks after the strobe.
// The result and flags are registered. A one-cycle done pulse reports each
// completion.
//
// Ports
//   clk, rst              : rising-edge clock, asynchronous active-high reset
//   alu_e                 : start strobe (honoured only in IDLE)
//   ALU_Cnt               : operation code
//   in_a, in_b            : operands A and B
//   shamt                 : shift amount (0..2**SHW-1)
//   result                : registered result, held until the next completion
//   flag_s/z/c/v          : sign / zero / carry / overflow flags
//   busy                  : high while a multi-cycle shift is in progress
//   done                  : one-cycle completion pulse
//   halt                  : sticky, set when HLT (1111) completes
// -----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_e,
    input  logic [3:0]       ALU_Cnt,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic             flag_s,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy,
    output logic             done,
    output logic             halt
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       kind_q, kind_d;       // low opcode bits select the shift flavour
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             s_q, s_d, z_q, z_d, c_q, c_d, v_q, v_d;
    logic             halt_q, halt_d;

    // One bit of shift/rotate. Returns {bit shifted out, new value}.
    function automatic logic [WIDTH:0] shift_step(input logic [1:0] kind,
                                                  input logic [WIDTH-1:0] w);
        logic [WIDTH:0] r;
        case (kind)
            2'b00:   r = {w[MSB], w[MSB-1:0], 1'b0};   // SLL
            2'b01:   r = {w[MSB], w[MSB-1:0], w[MSB]}; // rotate left
            2'b10:   r = {w[0], 1'b0, w[MSB:1]};       // SRL
            default: r = {w[0], w[MSB], w[MSB:1]};     // SRA
        endcase
        return r;
    endfunction

    logic [WIDTH:0]   sum, diff, step;
    logic [WIDTH-1:0] res;
    logic             upd, c_new, v_new;
    logic             is_long_shift;

    assign sum           = {1'b0, in_a} + {1'b0, in_b};
    assign diff          = {1'b0, in_a} - {1'b0, in_b};   // MSB is the borrow
    assign step          = shift_step(kind_q, work_q);
    assign is_long_shift = (ALU_Cnt[3:2] == 2'b10) && (shamt != '0);

    // State register and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            kind_q   <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            s_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            s_q      <= s_d;
            z_q      <= z_d;
            c_q      <= c_d;
            v_q      <= v_d;
            halt_q   <= halt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (alu_e) state_d = is_long_shift ? S_SHIFT : S_DONE;
            S_SHIFT: if (cnt_q == SHW'(1)) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        kind_d   = kind_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        s_d      = s_q;
        z_d      = z_q;
        c_d      = c_q;
        v_d      = v_q;
        halt_d   = halt_q;
        res      = in_a;
        upd      = 1'b0;
        c_new    = 1'b0;
        v_new    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (alu_e) begin
                    kind_d = ALU_Cnt[1:0];
                    if (is_long_shift) begin
                        work_d = in_a;
                        cnt_d  = shamt;
                    end else begin
                        case (ALU_Cnt)
                            4'b0000: begin
                                res   = sum[MSB:0];
                                upd   = 1'b1;
                                c_new = sum[WIDTH];
                                v_new = (in_a[MSB] == in_b[MSB]) && (sum[MSB] != in_a[MSB]);
                            end
                            4'b0001: begin
                                res   = diff[MSB:0];
                                upd   = 1'b1;
                                c_new = diff[WIDTH];
                                v_new = (in_a[MSB] != in_b[MSB]) && (diff[MSB] != in_a[MSB]);
                            end
                            4'b0010: begin res = in_a & in_b; upd = 1'b1; end
                            4'b0011: begin res = in_a | in_b; upd = 1'b1; end
                            4'b0100: begin res = in_a ^ in_b; upd = 1'b1; end
                            4'b0110: begin res = in_b;        upd = 1'b1; end
                            // Zero-length shift: pass A, carry cleared
                            4'b1000, 4'b1001,
                            4'b1010, 4'b1011: begin res = in_a; upd = 1'b1; end
                            4'b1100: res = in_b;
                            4'b1111: halt_d = 1'b1;
                            default: res = in_a;
                        endcase
                        result_d = res;
                        if (upd) begin
                            s_d = res[MSB];
                            z_d = (res == '0);
                            c_d = c_new;
                            v_d = v_new;
                        end
                    end
                end
            end
            S_SHIFT: begin
                work_d = step[MSB:0];
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    // Last bit: commit; carry is the final bit moved out
                    result_d = step[MSB:0];
                    s_d      = step[MSB];
                    z_d      = (step[MSB:0] == '0);
                    c_d      = step[WIDTH];
                    v_d      = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        busy   = (state_q == S_SHIFT);
        done   = (state_q == S_DONE);
        result = result_q;
        flag_s = s_q;
        flag_z = z_q;
        flag_c = c_q;
        flag_v = v_q;
        halt   = halt_q;
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: queue-based scoreboard against an arithmetic
// reference model, directed corner cases followed by randomized operations.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_e = 1'b0;
    logic [3:0]  ALU_Cnt = 4'h0;
    logic [15:0] in_a = 16'h0;
    logic [15:0] in_b = 16'h0;
    logic [3:0]  shamt = 4'h0;
    logic [15:0] result;
    logic        flag_s, flag_z, flag_c, flag_v, busy, done, halt;

    alu_exec_unit #(.WIDTH(16), .SHW(4)) dut (
        .clk(clk), .rst(rst), .alu_e(alu_e), .ALU_Cnt(ALU_Cnt),
        .in_a(in_a), .in_b(in_b), .shamt(shamt), .result(result),
        .flag_s(flag_s), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .busy(busy), .done(done), .halt(halt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] r;
        logic [3:0]  f;    // {S,Z,C,V}
        logic        h;
        int          due;  // cycle in which done must be seen
        logic [3:0]  op;
    } exp_t;

    exp_t sb[$];

    // Reference architectural state
    logic m_s = 1'b0, m_z = 1'b0, m_c = 1'b0, m_v = 1'b0, m_h = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model from the operation definitions, using plain integer math.
    task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int n, output logic [15:0] r, output int lat);
        int unsigned ua, ub, t;
        int          sa, sbv, st;
        bit          upd;
        logic        c, v;
        ua = a; ub = b;
        sa = $signed(a); sbv = $signed(b);
        upd = 1'b1; c = 1'b0; v = 1'b0; lat = 0; r = a;
        case (op)
            4'd0: begin t = ua + ub; r = 16'(t); c = (t > 65535); st = sa + sbv;
                        v = (st > 32767) || (st < -32768); end
            4'd1: begin t = ua - ub; r = 16'(t); c = (ua < ub); st = sa - sbv;
                        v = (st > 32767) || (st < -32768); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd6: r = b;
            4'd8, 4'd9, 4'd10, 4'd11: begin
                if (n > 0) begin
                    lat = n;
                    case (op)
                        4'd8:  begin r = 16'(ua << n); c = ((ua >> (16 - n)) & 1) != 0; end
                        4'd9:  begin r = 16'((ua << n) | (ua >> (16 - n)));
                                     c = ((ua >> (16 - n)) & 1) != 0; end
                        4'd10: begin r = 16'(ua >> n); c = ((ua >> (n - 1)) & 1) != 0; end
                        default: begin r = 16'(sa >>> n); c = ((ua >> (n - 1)) & 1) != 0; end
                    endcase
                end
            end
            4'd12: begin r = b; upd = 1'b0; end
            4'd15: begin upd = 1'b0; m_h = 1'b1; end
            default: upd = 1'b0;
        endcase
        if (upd) begin
            m_s = r[15]; m_z = (r == 16'h0); m_c = c; m_v = v;
        end
    endtask

    // Monitor: compare every completion against the oldest expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("result", 32'(result), 32'(e.r));
                chk("flags_szcv", 32'({flag_s, flag_z, flag_c, flag_v}), 32'(e.f));
                chk("halt", 32'(halt), 32'(e.h));
                chk("done_cycle", 32'(cyc), 32'(e.due));
                chk("busy_at_done", 32'(busy), 32'(0));
                $display("txn op=%b result=%h szcv=%b halt=%b cycle=%0d",
                         e.op, result, {flag_s, flag_z, flag_c, flag_v}, halt, cyc);
            end
        end
    end

    // Issue one operation; optionally re-strobe alu_e with other operands while busy.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int n, input bit poke);
        exp_t        e;
        logic [15:0] r;
        int          lat, t0;
        @(negedge clk);
        alu_e = 1'b1; ALU_Cnt = op; in_a = a; in_b = b; shamt = 4'(n);
        model(op, a, b, n, r, lat);
        e.r = r; e.f = {m_s, m_z, m_c, m_v}; e.h = m_h; e.op = op;
        @(posedge clk);
        #1;
        t0 = cyc;
        e.due = t0 + lat;
        sb.push_back(e);
        alu_e = 1'b0;
        if (lat > 0) begin
            @(negedge clk);
            chk("busy_during_shift", 32'(busy), 32'(1));
            if (poke) begin
                alu_e = 1'b1; ALU_Cnt = ~op; in_a = ~a; in_b = ~b; shamt = ~shamt;
                repeat (2) @(negedge clk);
                alu_e = 1'b0;
            end
        end
        while (cyc < t0 + lat + 1) @(posedge clk);
        #1;
        chk("done_seen", 32'(sb.size()), 32'(0));
        sb.delete();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [3:0]  op;
        logic [15:0] a, b;
        int          n;
        bit          poke;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_flags", 32'({flag_s, flag_z, flag_c, flag_v}), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_halt", 32'(halt), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Arithmetic corners
        issue(4'b0000, 16'h7FFF, 16'h0001, 0, 1'b0);
        issue(4'b0000, 16'hFFFF, 16'h0001, 0, 1'b0);
        issue(4'b0001, 16'h0003, 16'h0005, 0, 1'b0);
        issue(4'b0001, 16'h1234, 16'h1234, 0, 1'b0);
        issue(4'b0011, 16'hA5A0, 16'h000F, 0, 1'b0);

        // Asynchronous reset in the middle of SLL by 7
        @(negedge clk);
        alu_e = 1'b1; ALU_Cnt = 4'b1000; in_a = 16'h00F1; in_b = 16'h0; shamt = 4'd7;
        @(posedge clk);
        #1 alu_e = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("busy_before_abort", 32'(busy), 32'(1));
        #1 rst = 1'b1;
        #1;
        chk("abort_result", 32'(result), 32'(0));
        chk("abort_flags", 32'({flag_s, flag_z, flag_c, flag_v}), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        m_s = 1'b0; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0; m_h = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);   // monitor flags any stray done here
        issue(4'b0000, 16'h1111, 16'h2222, 0, 1'b0);

        // Shifts, ignored strobe, flag-preserving ops, halt
        issue(4'b1011, 16'h8001, 16'h0000, 4, 1'b0);
        issue(4'b1001, 16'h8001, 16'h0000, 1, 1'b0);
        issue(4'b1000, 16'h00F0, 16'h0000, 5, 1'b1);
        issue(4'b1010, 16'hF00F, 16'h0000, 15, 1'b1);
        issue(4'b1001, 16'hC003, 16'h0000, 0, 1'b0);
        issue(4'b0000, 16'hFFFF, 16'h0001, 0, 1'b0);
        issue(4'b1100, 16'h5555, 16'h00AA, 0, 1'b0);
        issue(4'b1111, 16'h4321, 16'h0000, 0, 1'b0);

        // Randomized operations
        for (int i = 0; i < 80; i++) begin
            op   = 4'($urandom_range(0, 15));
            a    = 16'($urandom);
            b    = 16'($urandom);
            n    = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
            poke = ($urandom_range(0, 3) == 0);
            issue(op, a, b, n, poke);
        end

        // Halt stays set until reset
        @(negedge clk);
        chk("halt_sticky", 32'(halt), 32'(m_h));
        #1 rst = 1'b1;
        #1;
        chk("halt_cleared", 32'(halt), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
